fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage between the program counter domain and the decoder. Owns the 5-bit PC, drives the program memory address, and registers the returned 6-bit instruction into a one-entry instruction register. That register is presented to the instruction decoder with a valid/ready handshake. Supports start/stop control, jump redirect with squash, and back-pressure stall.

## Interface
Parameters:
- PC_WIDTH, 5, program counter / program memory address width
- INS_WIDTH, 6, instruction width ({opcode[3:0], reg[1:0]}); equals `PM_ID_INS_WIDTH`

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin/resume fetching from current PC
- stop  input  1  suspend fetching
- jmp_en  input  1  redirect request
- jmp_addr  input  PC_WIDTH  redirect target
- pm_addr  output  PC_WIDTH  program memory address, equals PC (combinational from PC register)
- pm_ins  input  INS_WIDTH  program memory read data (combinational read of pm_addr)
- id_ins  output  INS_WIDTH  registered instruction to decoder
- id_pc  output  PC_WIDTH  address id_ins was fetched from
- id_valid  output  1  id_ins/id_pc hold a live instruction
- id_ready  input  1  decoder accepts id_ins this cycle
- busy  output  1  state is RUN
- halted  output  1  state is HALT (0 when feature compiled out)

## Operation
- States: IDLE, RUN, HALT (HALT only with macro).
- Reset: state IDLE, PC 0, id_ins 0, id_pc 0, id_valid 0, busy 0, halted 0; pm_addr therefore 0.
- Handshake: transfer occurs on an edge where id_valid && id_ready. id_ins/id_pc are stable while id_valid && !id_ready.
- Load condition (RUN, no jmp_en, no stop): when !id_valid || id_ready, id_ins <= pm_ins, id_pc <= PC, id_valid <= 1, PC <= PC+1 (mod 32). Otherwise hold (stall), PC unchanged.
- In RUN with no load, id_valid clears after a transfer.
- IDLE: start -> RUN. PC holds. A pending id_valid still drains via id_ready.
- stop in RUN -> IDLE; id_valid <= 0 (held instruction discarded); PC retained. On resume, fetch continues from PC.
- start && stop in the same cycle: stop wins.
- jmp_en (any state): PC <= jmp_addr, id_valid <= 0 (squash), no load that cycle. State: RUN stays RUN, HALT -> RUN, IDLE stays IDLE.
- Priority: rst > jmp_en > stop > start > load/stall.
- PC arithmetic: unsigned, PC_WIDTH bits; 31+1 wraps to 0 (without macro).

## Timing
- pm_addr to pm_ins is combinational within one cycle; the instruction is captured at the edge.
- Start latency: start sampled at edge N -> RUN at N; first load at edge N+1; id_valid=1 with Mem[PC] after N+1.
- Throughput: 1 instruction/cycle with id_ready held high.
- Jump: jmp_en at edge N -> id_valid 0 after N, PC = jmp_addr; Mem[jmp_addr] valid after N+1 (one bubble).
- Stall: id_ready low -> zero instructions lost or duplicated; PC frozen.

## Configuration
- FETCH_WRAP_HALT_EN defined: a load from PC=31 sets PC <= 0 and state -> HALT. In HALT no loads occur, halted=1, and id_valid drains normally. Exit is via jmp_en (-> RUN) or rst; start and stop are ignored in HALT.
- Not defined: PC wraps 31 -> 0 and fetching continues. No HALT state; halted tied 0.

## Test plan
- Reset, start, id_ready=1 with the program memory carry test image -> id_pc 0,1,2,… on consecutive cycles; id_ins equals Mem[id_pc] ({ADD_R,R1} at 0); busy=1.
- id_ready low for 3 cycles after id_pc=4 -> id_ins/id_pc held at Mem[4]/4, pm_addr held at 5; releasing gives 5,6,… with no gap or repeat.
- jmp_en with jmp_addr=14 while id_pc=8 is valid -> next cycle id_valid=0; following cycle id_pc=14, id_ins={LD_R,R2}.
- stop at id_pc=10, then start 3 cycles later -> id_valid 0 while IDLE; after resume first id_pc=11.
- Run past address 31 -> without macro id_pc 31 then 0; with FETCH_WRAP_HALT_EN, halted=1 after 31 is loaded, no further loads, and jmp_en to 0 resumes.
- rst asserted mid-run with id_valid=1 and id_ready=0 -> next cycle all outputs at reset values; start required to refetch from 0.

Source files
------------

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_if
// Purpose  : Bundles the fetch stage control inputs, the program memory port
//            and the decoder valid/ready handshake into one interface.
//            The master modport is the fetch unit side; the slave modport is
//            the surrounding control / memory / decoder side.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_unit_if #(
    parameter int PC_WIDTH  = 5,
    parameter int INS_WIDTH = 6
) ();
    logic                 start;
    logic                 stop;
    logic                 jmp_en;
    logic [PC_WIDTH-1:0]  jmp_addr;
    logic [PC_WIDTH-1:0]  pm_addr;
    logic [INS_WIDTH-1:0] pm_ins;
    logic [INS_WIDTH-1:0] id_ins;
    logic [PC_WIDTH-1:0]  id_pc;
    logic                 id_valid;
    logic                 id_ready;
    logic                 busy;
    logic                 halted;

    modport master (
        input  start, stop, jmp_en, jmp_addr, pm_ins, id_ready,
        output pm_addr, id_ins, id_pc, id_valid, busy, halted
    );

    modport slave (
        output start, stop, jmp_en, jmp_addr, pm_ins, id_ready,
        input  pm_addr, id_ins, id_pc, id_valid, busy, halted
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage. Owns the PC, drives the program memory
//            address and captures the returned instruction into a one-entry
//            instruction register offered to the decoder via valid/ready.
//            Supports start/stop, jump redirect with squash and stall.
// Options  : FETCH_WRAP_HALT_EN - loading the last address halts fetching
//            (HALT state) instead of wrapping around and continuing.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int PC_WIDTH  = 5,
    parameter int INS_WIDTH = 6
) (
    input  wire logic           clk,
    input  wire logic           rst,
    fetch_unit_if.master        bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1
`ifdef FETCH_WRAP_HALT_EN
        ,
        S_HALT = 2'd2
`endif
    } state_t;

    localparam logic [PC_WIDTH-1:0] c_pc_one  = {{(PC_WIDTH-1){1'b0}}, 1'b1};
`ifdef FETCH_WRAP_HALT_EN
    localparam logic [PC_WIDTH-1:0] c_pc_last = {PC_WIDTH{1'b1}};
`endif

    state_t                r_state;
    logic [PC_WIDTH-1:0]   r_pc;
    logic [INS_WIDTH-1:0]  r_id_ins;
    logic [PC_WIDTH-1:0]   r_id_pc;
    logic                  r_id_valid;

    state_t                w_state_nxt;
    logic [PC_WIDTH-1:0]   w_pc_nxt;
    logic [INS_WIDTH-1:0]  w_id_ins_nxt;
    logic [PC_WIDTH-1:0]   w_id_pc_nxt;
    logic                  w_id_valid_nxt;
    logic                  w_xfer;

    // The decoder consumes the held instruction on this edge.
    assign w_xfer = r_id_valid && bus.id_ready;

    // State register and fetch datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_id_ins   <= '0;
            r_id_pc    <= '0;
            r_id_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_id_ins   <= w_id_ins_nxt;
            r_id_pc    <= w_id_pc_nxt;
            r_id_valid <= w_id_valid_nxt;
        end
    end

    // Next state and next datapath values; priority jmp_en > stop > start > load/stall.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_id_ins_nxt   = r_id_ins;
        w_id_pc_nxt    = r_id_pc;
        w_id_valid_nxt = r_id_valid;

        if (bus.jmp_en) begin
            // Redirect squashes whatever is held; one bubble before the target arrives.
            w_pc_nxt       = bus.jmp_addr;
            w_id_valid_nxt = 1'b0;
            if (r_state != S_IDLE) begin
                w_state_nxt = S_RUN;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A previously fetched instruction may still drain to the decoder.
                    if (w_xfer) begin
                        w_id_valid_nxt = 1'b0;
                    end
                    if (bus.start && !bus.stop) begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.stop) begin
                        w_state_nxt    = S_IDLE;
                        w_id_valid_nxt = 1'b0;
                    end else if (!r_id_valid || bus.id_ready) begin
                        w_id_ins_nxt   = bus.pm_ins;
                        w_id_pc_nxt    = r_pc;
                        w_id_valid_nxt = 1'b1;
                        w_pc_nxt       = r_pc + c_pc_one;
`ifdef FETCH_WRAP_HALT_EN
                        if (r_pc == c_pc_last) begin
                            w_state_nxt = S_HALT;
                        end
`endif
                    end
                end
`ifdef FETCH_WRAP_HALT_EN
                S_HALT: begin
                    // No further loads; start/stop are ignored until a jump.
                    if (w_xfer) begin
                        w_id_valid_nxt = 1'b0;
                    end
                end
`endif
                default: begin
                    w_state_nxt    = S_IDLE;
                    w_id_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    assign bus.pm_addr  = r_pc;
    assign bus.id_ins   = r_id_ins;
    assign bus.id_pc    = r_id_pc;
    assign bus.id_valid = r_id_valid;
    assign bus.busy     = (r_state == S_RUN);
`ifdef FETCH_WRAP_HALT_EN
    assign bus.halted   = (r_state == S_HALT);
`else
    assign bus.halted   = 1'b0;
`endif

endmodule
`default_nettype wire
